// File: rtl/sync_transmitter.sv
// Serial frame transmitter: start, 32 data bits LSB first, even parity, stop bits.
// Optional SYNC_TX_ERR_INJECT_EN adds Inject_Err to invert one frame's parity.
module sync_transmitter #(
  parameter int DATA_WIDTH = 32,
  parameter int STOP_BITS  = 2
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  CLK_Baud,
  input  logic [DATA_WIDTH-1:0] Data,
  input  logic                  Send,
`ifdef SYNC_TX_ERR_INJECT_EN
  input  logic                  Inject_Err,
`endif
  output logic                  Serial_output,
  output logic                  Busy,
  output logic                  Done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ARM    = 3'd1;
  localparam logic [2:0] START  = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] PARITY = 3'd4;
  localparam logic [2:0] STOP   = 3'd5;

  localparam logic [5:0] CNT_DATA = 6'(DATA_WIDTH);
  localparam logic [5:0] CNT_STOP = 6'(STOP_BITS);

  logic [2:0]            state;
  logic [5:0]            cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par;
  logic                  par_in;
  logic                  baud_o;
  logic                  fall;

  assign fall = baud_o & ~CLK_Baud;

`ifdef SYNC_TX_ERR_INJECT_EN
  assign par_in = (^Data) ^ Inject_Err;
`else
  assign par_in = ^Data;
`endif

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state         <= IDLE;
      cnt           <= '0;
      shift_reg     <= '0;
      par           <= 1'b0;
      baud_o        <= 1'b0;
      Serial_output <= 1'b1;
      Busy          <= 1'b0;
      Done          <= 1'b0;
    end else begin
      baud_o <= CLK_Baud;
      Done   <= 1'b0;
      unique case (state)
        IDLE: begin
          Serial_output <= 1'b1;
          if (Send) begin
            shift_reg <= Data;
            par       <= par_in;
            Busy      <= 1'b1;
            state     <= ARM;
          end
        end
        ARM: begin
          if (fall) begin
            Serial_output <= 1'b0;
            state         <= START;
          end
        end
        START: begin
          if (fall) begin
            Serial_output <= shift_reg[0];
            shift_reg     <= shift_reg >> 1;
            cnt           <= 6'd1;
            state         <= DATA;
          end
        end
        DATA: begin
          if (fall) begin
            if (cnt < CNT_DATA) begin
              Serial_output <= shift_reg[0];
              shift_reg     <= shift_reg >> 1;
              cnt           <= cnt + 6'd1;
            end else begin
              Serial_output <= par;
              state         <= PARITY;
            end
          end
        end
        PARITY: begin
          if (fall) begin
            Serial_output <= 1'b1;
            cnt           <= 6'd1;
            state         <= STOP;
          end
        end
        STOP: begin
          if (fall) begin
            if (cnt < CNT_STOP) begin
              cnt <= cnt + 6'd1;
            end else begin
              Busy  <= 1'b0;
              Done  <= 1'b1;
              state <= IDLE;
            end
          end
        end
        default: begin
          Serial_output <= 1'b1;
          Busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_transmitter.sv
// Directed bench for sync_transmitter: frame content, handshake and corner timing.
// Frames are sampled on rising CLK_Baud edges, as the receiver would.
module tb_sync_transmitter;

`ifdef SYNC_TX_ERR_INJECT_EN
  localparam bit INJ_ON = 1'b1;
`else
  localparam bit INJ_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    int          send_len;
    bit          mid_send;
    bit          inj;
    bit          exp_par;
  } vec_t;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        CLK_Baud = 1'b0;
  logic        Send = 1'b0;
  logic [31:0] Data = '0;
`ifdef SYNC_TX_ERR_INJECT_EN
  logic        Inject_Err = 1'b0;
`endif
  logic        Serial_output;
  logic        Busy;
  logic        Done;
  bit          baud_en = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;

  sync_transmitter dut (
    .CLK           (CLK),
    .CLR           (CLR),
    .CLK_Baud      (CLK_Baud),
    .Data          (Data),
    .Send          (Send),
`ifdef SYNC_TX_ERR_INJECT_EN
    .Inject_Err    (Inject_Err),
`endif
    .Serial_output (Serial_output),
    .Busy          (Busy),
    .Done          (Done)
  );

  always #5 CLK = ~CLK;
  // baud edges land on CLK falling edges, away from the sampling edge
  always #40 if (baud_en) CLK_Baud = ~CLK_Baud;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_inj(input bit v);
`ifdef SYNC_TX_ERR_INJECT_EN
    Inject_Err = v;
`else
    if (v) Data = Data;
`endif
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (Done !== 1'b1 && k < 400) begin
      @(posedge CLK); #1;
      k++;
    end
    chk(name, 32'(Done), 32'd1);
  endtask

  task automatic run_frame(input vec_t v);
    logic [35:0] b;
    int k;
    int nd;
    @(posedge CLK_Baud);
    @(posedge CLK); #1;
    Data = v.data;
    Send = 1'b1;
    set_inj(v.inj);
    repeat (v.send_len) begin
      @(posedge CLK); #1;
    end
    Send = 1'b0;
    Data = ~v.data;
    set_inj(1'b0);
    k = 0;
    while (Serial_output !== 1'b0 && k < 40) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("start_edge_seen", 32'(k < 40), 32'd1);
    for (int i = 0; i < 36; i++) begin
      @(posedge CLK_Baud);
      b[i] = Serial_output;
      if (i == 20) chk("busy_mid_frame", 32'(Busy), 32'd1);
      if (v.mid_send && i == 10) begin
        @(posedge CLK); #1;
        Data = 32'hFFFF_FFFF;
        Send = 1'b1;
        @(posedge CLK); #1;
        Send = 1'b0;
      end
    end
    chk("start_bit", 32'(b[0]), 32'd0);
    chk("payload", b[32:1], v.data);
    chk("parity_bit", 32'(b[33]), 32'(v.exp_par));
    chk("stop_bits", 32'(b[35:34]), 32'd3);
    nd = 0;
    repeat (12) begin
      @(posedge CLK); #1;
      if (Done === 1'b1) nd++;
    end
    chk("done_pulses", 32'(nd), 32'd1);
    chk("busy_after", 32'(Busy), 32'd0);
    chk("line_idle_after", 32'(Serial_output), 32'd1);
  endtask

  vec_t vecs[6];

  initial begin
    bit bad;
    vec_t last;
    vecs[0] = '{32'hA5A5_0F0F, 1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0001, 1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{32'hFFFF_FFFF, 1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h8000_0000, 5, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{32'h0000_0000, 1, 1'b0, 1'b1, INJ_ON};
    vecs[5] = '{32'h0000_0000, 1, 1'b0, 1'b0, 1'b0};
    last    = '{32'h1234_5678, 1, 1'b0, 1'b0, 1'b1};

    repeat (3) @(posedge CLK);
    #1;
    chk("rst_line", 32'(Serial_output), 32'd1);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    CLR = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(posedge CLK); #1;
      if (Serial_output !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) bad = 1'b1;
    end
    chk("idle_quiet", 32'(bad), 32'd0);

    for (int i = 0; i < 6; i++) run_frame(vecs[i]);

    // first falling line edge lands one CLK after the baud fall
    @(posedge CLK_Baud);
    @(posedge CLK); #1;
    Data = 32'h0000_000F;
    Send = 1'b1;
    @(posedge CLK); #1;
    Send = 1'b0;
    chk("accept_busy", 32'(Busy), 32'd1);
    @(negedge CLK_Baud);
    chk("line_before_fall", 32'(Serial_output), 32'd1);
    @(posedge CLK); #1;
    chk("line_latency", 32'(Serial_output), 32'd0);
    wait_done("latency_frame_done");

    // Send held across Done: ignored on the Done edge, taken on the next
    @(posedge CLK); #1;
    Data = 32'h0000_0005;
    Send = 1'b1;
    @(posedge CLK); #1;
    wait_done("held_send_done");
    chk("busy_at_done", 32'(Busy), 32'd0);
    @(posedge CLK); #1;
    chk("accept_after_done", 32'(Busy), 32'd1);
    Send = 1'b0;
    wait_done("second_frame_done");

    // static baud clock freezes the frame
    @(posedge CLK_Baud);
    @(posedge CLK); #1;
    baud_en = 1'b0;
    Send = 1'b1;
    @(posedge CLK); #1;
    Send = 1'b0;
    repeat (50) @(posedge CLK);
    #1;
    chk("static_busy", 32'(Busy), 32'd1);
    chk("static_line", 32'(Serial_output), 32'd1);
    baud_en = 1'b1;
    wait_done("static_resume_done");

    // reset mid-frame while an all-zero payload holds the line low
    @(posedge CLK_Baud);
    @(posedge CLK); #1;
    Data = 32'h0000_0000;
    Send = 1'b1;
    @(posedge CLK); #1;
    Send = 1'b0;
    repeat (12) @(posedge CLK_Baud);
    chk("pre_abort_line", 32'(Serial_output), 32'd0);
    @(posedge CLK); #1;
    CLR = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0;
    chk("abort_line", 32'(Serial_output), 32'd1);
    chk("abort_busy", 32'(Busy), 32'd0);
    bad = 1'b0;
    repeat (30) begin
      @(posedge CLK); #1;
      if (Serial_output !== 1'b1 || Busy !== 1'b0 || Done !== 1'b0) bad = 1'b1;
    end
    chk("abort_quiet", 32'(bad), 32'd0);
    run_frame(last);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
